// File: rtl/midi_message_decoder.sv
// MIDI byte-stream parser: turns channel note-on/note-off messages into single-cycle
// note events, with running status, realtime interleaving and per-channel active-note tracking.
module midi_message_decoder #(
  parameter int CHANNELS  = 3,
  parameter int BASE_NOTE = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                note_on,
  output logic [3:0]          note_out,
  output logic [1:0]          octave_out,
  output logic [3:0]          channel_out,
  output logic [CHANNELS-1:0] note_off,
  output logic                parse_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA1 = 2'd1,
    ST_DATA2 = 2'd2
  } state_t;

  localparam logic [4:0] CH_LIM = 5'(CHANNELS);
  localparam logic [7:0] KEY_LO = 8'(BASE_NOTE);
  localparam logic [7:0] KEY_HI = 8'(BASE_NOTE + 47);

  // Splits a 0..47 offset into {octave, note within octave} without a divider.
  function automatic logic [5:0] split_note(input logic [5:0] diff);
    logic [1:0] oct;
    logic [5:0] rem;
    if (diff >= 6'd36) begin
      oct = 2'd3;
      rem = diff - 6'd36;
    end else if (diff >= 6'd24) begin
      oct = 2'd2;
      rem = diff - 6'd24;
    end else if (diff >= 6'd12) begin
      oct = 2'd1;
      rem = diff - 6'd12;
    end else begin
      oct = 2'd0;
      rem = diff;
    end
    return {oct, rem[3:0]};
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          kind_r;
  logic [3:0]          chan_r;
  logic [6:0]          key_r;
  logic                sysex_r;
  logic [CHANNELS-1:0] active_r;
  logic [6:0]          active_key_r [CHANNELS];

  logic                is_data_s;
  logic                is_chan_s;
  logic                is_sysc_s;
  logic                one_byte_s;
  logic                msg_done_s;
  logic                chan_ok_s;
  logic                key_ok_s;
  logic                is_on_s;
  logic                is_off_s;
  logic                on_fire_s;
  logic                off_req_s;
  logic [5:0]          diff_s;

  logic                note_on_s;
  logic [3:0]          note_out_s;
  logic [1:0]          octave_out_s;
  logic [3:0]          channel_out_s;
  logic [CHANNELS-1:0] note_off_s;
  logic                parse_error_s;
  logic [CHANNELS-1:0] active_s;
  logic [6:0]          active_key_s [CHANNELS];

  // Byte classification and message-completion decode; realtime bytes match no class.
  always_comb begin
    is_data_s  = byte_valid && (byte_in[7] == 1'b0);
    is_chan_s  = byte_valid && (byte_in[7] == 1'b1) && (byte_in[7:4] != 4'hF);
    is_sysc_s  = byte_valid && (byte_in[7:3] == 5'b11110);
    one_byte_s = (kind_r == 4'hC) || (kind_r == 4'hD);
    msg_done_s = is_data_s && (state_r == ST_DATA2);
    chan_ok_s  = ({1'b0, chan_r} < CH_LIM);
    key_ok_s   = ({1'b0, key_r} >= KEY_LO) && ({1'b0, key_r} <= KEY_HI);
    is_on_s    = (kind_r == 4'h9) && (byte_in[6:0] != 7'd0);
    is_off_s   = (kind_r == 4'h8) || ((kind_r == 4'h9) && (byte_in[6:0] == 7'd0));
    on_fire_s  = msg_done_s && chan_ok_s && is_on_s && key_ok_s;
    off_req_s  = msg_done_s && chan_ok_s && is_off_s;
    diff_s     = 6'({1'b0, key_r} - KEY_LO);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; any status byte abandons a partial message.
  always_comb begin
    state_s = state_r;
    if (is_chan_s) begin
      state_s = ST_DATA1;
    end else if (is_sysc_s) begin
      state_s = ST_IDLE;
    end else if (is_data_s) begin
      case (state_r)
        ST_IDLE:  state_s = ST_IDLE;
        ST_DATA1: state_s = one_byte_s ? ST_DATA1 : ST_DATA2;
        ST_DATA2: state_s = ST_DATA1;
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Running-status latch, key capture and SysEx-swallow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_r  <= 4'd0;
      chan_r  <= 4'd0;
      key_r   <= 7'd0;
      sysex_r <= 1'b0;
    end else if (is_chan_s) begin
      kind_r  <= byte_in[7:4];
      chan_r  <= byte_in[3:0];
      sysex_r <= 1'b0;
    end else if (is_sysc_s) begin
      sysex_r <= 1'b1;
    end else if (is_data_s && (state_r == ST_DATA1)) begin
      key_r <= byte_in[6:0];
    end
  end

  // Output logic: next event values and per-channel active-note bookkeeping.
  always_comb begin
    note_on_s     = on_fire_s;
    note_out_s    = note_out;
    octave_out_s  = octave_out;
    channel_out_s = channel_out;
    note_off_s    = '0;
    active_s      = active_r;
    active_key_s  = active_key_r;
    parse_error_s = parse_error || (is_data_s && (state_r == ST_IDLE) && !sysex_r);
    if (on_fire_s) begin
      {octave_out_s, note_out_s} = split_note(diff_s);
      channel_out_s              = chan_r;
    end else begin
      channel_out_s = channel_out;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      note_off_s[i]   = off_req_s && (chan_r == 4'(i)) && active_r[i] && (active_key_r[i] == key_r);
      active_s[i]     = (on_fire_s && (chan_r == 4'(i))) ? 1'b1 :
                        (note_off_s[i] ? 1'b0 : active_r[i]);
      active_key_s[i] = (on_fire_s && (chan_r == 4'(i))) ? key_r : active_key_r[i];
    end
  end

  // Registered outputs and active-note table.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_on     <= 1'b0;
      note_out    <= 4'd0;
      octave_out  <= 2'd0;
      channel_out <= 4'd0;
      note_off    <= '0;
      parse_error <= 1'b0;
      active_r    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active_key_r[i] <= 7'd0;
      end
    end else begin
      note_on      <= note_on_s;
      note_out     <= note_out_s;
      octave_out   <= octave_out_s;
      channel_out  <= channel_out_s;
      note_off     <= note_off_s;
      parse_error  <= parse_error_s;
      active_r     <= active_s;
      active_key_r <= active_key_s;
    end
  end

endmodule

// File: tb/tb_midi_message_decoder.sv
// Bench for midi_message_decoder: directed cases plus random byte streams
// scored against a message-level reference model.
module tb_midi_message_decoder;
  localparam int CHANNELS  = 3;
  localparam int BASE_NOTE = 48;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          byte_in = 8'd0;
  logic                byte_valid = 1'b0;
  logic                note_on;
  logic [3:0]          note_out;
  logic [1:0]          octave_out;
  logic [3:0]          channel_out;
  logic [CHANNELS-1:0] note_off;
  logic                parse_error;

  midi_message_decoder #(.CHANNELS(CHANNELS), .BASE_NOTE(BASE_NOTE)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .note_on(note_on), .note_out(note_out), .octave_out(octave_out),
    .channel_out(channel_out), .note_off(note_off), .parse_error(parse_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int rs_status;
  bit sysex_m;
  int dq[$];
  bit perr_m;
  bit act_m [16];
  int akey_m [16];
  bit e_on;
  int e_note, e_oct, e_ch, e_off;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rs_status = 0; sysex_m = 0; dq.delete(); perr_m = 0;
    for (int i = 0; i < 16; i++) begin act_m[i] = 0; akey_m[i] = 0; end
    e_on = 0; e_note = 0; e_oct = 0; e_ch = 0; e_off = 0;
  endtask

  task automatic model_complete();
    int ch, kind, key, vel;
    ch = rs_status % 16;
    kind = rs_status / 16;
    if (dq.size() < 2) return;
    key = dq[0];
    vel = dq[1];
    if (ch >= CHANNELS) return;
    if (kind == 9 && vel != 0) begin
      if (key >= BASE_NOTE && key < BASE_NOTE + 48) begin
        e_on = 1; e_note = (key - BASE_NOTE) % 12; e_oct = (key - BASE_NOTE) / 12; e_ch = ch;
        act_m[ch] = 1; akey_m[ch] = key;
      end
    end else if (kind == 8 || (kind == 9 && vel == 0)) begin
      if (act_m[ch] && akey_m[ch] == key) begin
        e_off = 1 << ch; act_m[ch] = 0;
      end
    end
  endtask

  task automatic model_byte(input int b, input bit v);
    int need;
    e_on = 0; e_off = 0;
    if (!v || b >= 'hF8) return;
    if (b >= 'hF0) begin rs_status = 0; sysex_m = 1; dq.delete(); return; end
    if (b >= 'h80) begin rs_status = b; sysex_m = 0; dq.delete(); return; end
    if (rs_status == 0) begin
      if (!sysex_m) perr_m = 1;
      return;
    end
    dq.push_back(b);
    need = (rs_status / 16 == 'hC || rs_status / 16 == 'hD) ? 1 : 2;
    if (dq.size() == need) begin
      model_complete();
      dq.delete();
    end
  endtask

  task automatic compare_all(input string ctx);
    check_value({ctx, "_note_on"}, note_on, e_on);
    check_value({ctx, "_note_off"}, note_off, e_off);
    check_value({ctx, "_parse_error"}, parse_error, perr_m);
    check_value({ctx, "_note_out"}, note_out, e_note);
    check_value({ctx, "_octave_out"}, octave_out, e_oct);
    check_value({ctx, "_channel_out"}, channel_out, e_ch);
  endtask

  task automatic send(input logic [7:0] b, input logic v);
    @(negedge clk);
    byte_in = b; byte_valid = v;
    model_byte(int'(b), v);
    @(posedge clk); #1;
    compare_all("stream");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; byte_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  int pool [6] = '{47, 48, 59, 60, 95, 96};

  initial begin
    int r, k, kind, d;
    logic [7:0] b;
    model_reset();
    do_reset();

    // basic note-on
    send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
    check_value("tp_on_pulse", note_on, 1); check_value("tp_on_note", note_out, 0);
    check_value("tp_on_oct", octave_out, 1); check_value("tp_on_ch", channel_out, 0);
    send(8'h00, 1'b0);
    check_value("tp_on_deassert", note_on, 0);

    // running status
    send(8'h91, 1'b1); send(8'h30, 1'b1); send(8'h40, 1'b1);
    check_value("rs1_ch", channel_out, 1); check_value("rs1_note", note_out, 0);
    send(8'h33, 1'b1); send(8'h40, 1'b1);
    check_value("rs2_pulse", note_on, 1); check_value("rs2_note", note_out, 3);
    check_value("rs2_oct", octave_out, 0);

    // release, double release, key mismatch
    send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h00, 1'b1);
    check_value("rel_off", note_off, 3'b001);
    send(8'h80, 1'b1); send(8'h3C, 1'b1); send(8'h00, 1'b1);
    check_value("rel_again", note_off, 3'b000);
    send(8'h90, 1'b1); send(8'h3E, 1'b1); send(8'h40, 1'b1);
    send(8'h80, 1'b1); send(8'h3C, 1'b1); send(8'h40, 1'b1);
    check_value("rel_mismatch", note_off, 3'b000);

    // realtime interleaving
    send(8'h92, 1'b1); send(8'hF8, 1'b1); send(8'h40, 1'b1); send(8'hFE, 1'b1); send(8'h7F, 1'b1);
    check_value("rt_ch", channel_out, 2); check_value("rt_note", note_out, 4);
    check_value("rt_oct", octave_out, 1); check_value("rt_pulse", note_on, 1);

    // filtering
    send(8'h95, 1'b1); send(8'h40, 1'b1); send(8'h7F, 1'b1);
    send(8'h90, 1'b1); send(8'h2F, 1'b1); send(8'h7F, 1'b1);
    send(8'h90, 1'b1); send(8'h60, 1'b1); send(8'h7F, 1'b1);
    check_value("flt_hi", note_on, 0);
    send(8'hC0, 1'b1); send(8'h05, 1'b1); send(8'h05, 1'b1);
    check_value("flt_perr", parse_error, 0);

    // errors and reset behaviour
    do_reset();
    send(8'h40, 1'b1);
    check_value("err_orphan", parse_error, 1);
    do_reset();
    send(8'hF0, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'hF7, 1'b1); send(8'h10, 1'b1);
    check_value("err_sysex", parse_error, 0);
    do_reset();
    send(8'h90, 1'b1);
    do_reset();
    send(8'h3C, 1'b1); send(8'h40, 1'b1);
    check_value("err_midreset_on", note_on, 0);
    check_value("err_midreset_perr", parse_error, 1);

    // randomized stream
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        do_reset();
        continue;
      end
      r = r % 100;
      if (r < 8) begin
        send(8'h00, 1'b0);
      end else if (r < 12) begin
        b = 8'(8'hF8 + $urandom_range(0, 7));
        send(b, 1'b1);
      end else if (r < 14) begin
        b = 8'(8'hF0 + $urandom_range(0, 7));
        send(b, 1'b1);
      end else if (r < 32) begin
        k = $urandom_range(0, 9);
        kind = (k < 4) ? 9 : (k < 7) ? 8 : (k < 8) ? 'hC : (k < 9) ? 'hD : 'hA;
        b = 8'(kind * 16 + $urandom_range(0, 4));
        send(b, 1'b1);
      end else begin
        d = $urandom_range(0, 9);
        if (d < 2) b = 8'h00;
        else if (d < 7) b = 8'(pool[$urandom_range(0, 5)]);
        else b = 8'($urandom_range(0, 127));
        send(b, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_message_decoder.md
Name: midi_message_decoder

Overview:
Parses a raw MIDI byte stream from the UART receiver into per-channel note events. It emits single-cycle note-on pulses (note within octave, octave, channel) and a one-hot note-off vector, the same event format the MIDI status input buffer consumes. Handles running status, velocity-0 note-off, realtime byte interleaving and per-channel active-note tracking, so only the sounding note can be released.

Parameters:
CHANNELS, 3, number of voice channels handled (channels >= CHANNELS are ignored; max 16)
BASE_NOTE, 48, MIDI note number mapped to note 0 / octave 0; playable range BASE_NOTE..BASE_NOTE+47

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
byte_in  input  8  received MIDI byte
byte_valid  input  1  byte_in valid this cycle; one byte consumed per asserted cycle (no backpressure)
note_on  output  1  one-cycle pulse: note-on event
note_out  output  4  note within octave, 0..11, valid with note_on
octave_out  output  2  octave, 0..3, valid with note_on
channel_out  output  4  MIDI channel, valid with note_on
note_off  output  CHANNELS  one-hot one-cycle pulse: release channel i
parse_error  output  1  sticky: data byte received with no running status; cleared only by reset

Behaviour:
- Reset: note_on=0, note_off=0, parse_error=0, note_out/octave_out/channel_out=0, FSM=IDLE, running status cleared, all channel active flags cleared.
- Byte classes: status = bit7 set; realtime = 0xF8..0xFF; system common = 0xF0..0xF7; data = bit7 clear.
- Realtime bytes are ignored entirely: no state, running-status or output change.
- System common bytes clear running status and go to IDLE; following data bytes are discarded without parse_error until the next channel status byte (SysEx payload swallowed).
- Channel status 0x80..0xEF: latch kind (high nibble) and channel (low nibble), go to DATA1. The length is 1 data byte for 0xC_/0xD_ and 2 for all others.
- FSM states:
  - IDLE: data byte -> discard; set parse_error only if no SysEx/system-common is in progress.
  - DATA1: data byte -> latch as key. A 1-byte kind completes the message (discarded) and returns to DATA1 (running status). A 2-byte kind goes to DATA2.
  - DATA2: data byte -> latch velocity, message complete, return to DATA1 (running status).
  - A status byte in any state restarts as above and abandons any partial message.
- Message actions on completion (only when channel < CHANNELS; otherwise discard):
  - 0x9_ with velocity != 0 and key in range: note_on pulse, outputs diff = key - BASE_NOTE, note_out = diff mod 12, octave_out = diff / 12, channel_out = channel. Record active[ch]=1, active_key[ch]=key.
  - 0x8_, or 0x9_ with velocity 0: if active[ch] and key == active_key[ch], assert note_off[ch] and clear active[ch]. Otherwise no output.
  - Key out of range on note-on: no output, active state unchanged.
  - All other kinds: discarded.
- Latency: outputs pulse exactly one cycle after the byte_valid cycle carrying the completing data byte. Pulses last one cycle; outputs deassert the next cycle unless another message completes. note_out/octave_out/channel_out hold their last values between pulses.
- Back-to-back complete messages on consecutive byte cycles produce consecutive pulses; there is no internal queue.
- Note-on to a channel already active replaces active_key; no note_off is generated.
- Reset mid-message: partial message discarded, running status lost.

Test Plan:
- 0x90,0x3C,0x64 (BASE_NOTE=48) -> one cycle after the last byte: note_on=1, note_out=0, octave_out=1, channel_out=0; note_off=0.
- Running status: 0x91,0x30,0x40,0x33,0x40 -> two note_on pulses on ch1: (note 0, oct 0) then (note 3, oct 0).
- Release: after note-on ch0 key 0x3C, send 0x90,0x3C,0x00 -> note_off=3'b001; then 0x80,0x3C,0x00 -> no pulse (already released); then note-on 0x3E and 0x80,0x3C,0x40 -> no pulse (key mismatch).
- Interleaving: 0x92,0xF8,0x40,0xFE,0x7F -> note_on ch2, note_out=4, octave_out=1; realtime bytes have no effect.
- Filtering: 0x95,0x40,0x7F (ch5 >= CHANNELS) -> no output; 0x90,0x2F,0x7F and 0x90,0x60,0x7F (out of range) -> no output; 0xC0,0x05,0x05 -> no output, no parse_error.
- Errors/reset: after reset, 0x40 -> parse_error=1; 0xF0,0x01,0x02,0xF7,0x10 -> no further parse_error change (SysEx/system-common swallowed); assert reset between 0x90 and 0x3C, then send 0x3C,0x40 -> no note_on, parse_error=1.
